// File: rtl/gcd_ctrl.sv
// ============================================================================
// Module   : gcd_ctrl
// Purpose  : Moore control FSM for a 32-bit subtractive GCD datapath with a
//            start/done handshake, a saturating iteration counter and an
//            optional runaway timeout (enabled by defining GCD_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gcd_ctrl #(
  parameter int          CNT_W    = 16,
  parameter int unsigned MAX_ITER = 32'h0000_FFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             lt,
  input  logic             gt,
  input  logic             eq,
  input  logic             zero,
  output logic             lda,
  output logic             ldb,
  output logic             sel_in,
  output logic             sel1,
  output logic             sel2,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_COMPARE = 3'd3,
    S_SUB_A   = 3'd4,
    S_SUB_B   = 3'd5,
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_iter_cnt;
  logic             w_timeout;

`ifdef GCD_TIMEOUT_EN
  assign w_timeout = (r_iter_cnt == CNT_W'(MAX_ITER));
`else
  logic w_unused_max_iter;
  assign w_unused_max_iter = (MAX_ITER == 0);
  assign w_timeout         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_iter_cnt <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_LOAD_A: r_iter_cnt <= '0;
        S_SUB_A,
        S_SUB_B: begin
          if (r_iter_cnt != c_CNT_MAX)
            r_iter_cnt <= r_iter_cnt + 1'b1;
        end
        default: r_iter_cnt <= r_iter_cnt;
      endcase
    end
  end

  // Status priority in COMPARE: zero, equal, timeout, then direction.
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:    w_next = start ? S_LOAD_A : S_IDLE;
      S_LOAD_A:  w_next = S_LOAD_B;
      S_LOAD_B:  w_next = S_COMPARE;
      S_COMPARE: begin
        if (zero)           w_next = S_ERR;
        else if (eq)        w_next = S_DONE;
        else if (w_timeout) w_next = S_ERR;
        else if (gt)        w_next = S_SUB_A;
        else if (lt)        w_next = S_SUB_B;
        else                w_next = S_ERR;
      end
      S_SUB_A:   w_next = S_COMPARE;
      S_SUB_B:   w_next = S_COMPARE;
      S_DONE:    w_next = S_IDLE;
      S_ERR:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    lda    = 1'b0;
    ldb    = 1'b0;
    sel_in = 1'b0;
    sel1   = 1'b0;
    sel2   = 1'b0;
    busy   = (r_state != S_IDLE);
    done   = 1'b0;
    err    = 1'b0;
    case (r_state)
      S_LOAD_A: begin
        lda    = 1'b1;
        sel_in = 1'b1;
      end
      S_LOAD_B: begin
        ldb    = 1'b1;
        sel_in = 1'b1;
      end
      S_SUB_A: begin
        lda  = 1'b1;
        sel2 = 1'b1;
      end
      S_SUB_B: begin
        ldb  = 1'b1;
        sel1 = 1'b1;
      end
      S_DONE: done = 1'b1;
      S_ERR: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

  assign iter_cnt = r_iter_cnt;

endmodule

`default_nettype wire
